// File: rtl/asymmetric_fifo_pkg.sv
// -----------------------------------------------------------------------------
// asymmetric_fifo_pkg
// Derived constants shared by the asymmetric FIFO and its RAM:
//   calc_ratio       - lanes per wide entry (WIDTH_IN / WIDTH_OUT)
//   calc_lane_width  - lane select width, never below 1 bit
//   calc_count_width - occupancy counter width (address width + 1)
// -----------------------------------------------------------------------------
package asymmetric_fifo_pkg;

    function automatic int calc_ratio(input int width_in, input int width_out);
        return width_in / width_out;
    endfunction

    function automatic int calc_lane_width(input int ratio);
        return (ratio > 1) ? $clog2(ratio) : 1;
    endfunction

    function automatic int calc_count_width(input int addr_width);
        return addr_width + 1;
    endfunction

endpackage

// File: rtl/asymmetric_distributed_ram.sv
// -----------------------------------------------------------------------------
// asymmetric_distributed_ram
// Wide synchronous write port, narrow asynchronous read port. No reset: the
// contents are don't-care until written.
// Ports:
//   clk     - write clock
//   we      - write enable
//   addr_a  - wide entry address for writes
//   din_a   - wide write word, lane 0 in the LSBs
//   addr_b  - narrow read address {entry, lane}
//   dout_b  - selected lane (combinational)
// -----------------------------------------------------------------------------
module asymmetric_distributed_ram
    import asymmetric_fifo_pkg::*;
#(
    parameter int WIDTH_IN  = 64,
    parameter int WIDTH_OUT = 16,
    parameter int DEPTH     = 32,
    localparam int AW       = $clog2(DEPTH),
    localparam int RATIO    = calc_ratio(WIDTH_IN, WIDTH_OUT),
    localparam int LW       = calc_lane_width(RATIO)
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [AW-1:0]        addr_a,
    input  logic [WIDTH_IN-1:0]  din_a,
    input  logic [AW+LW-1:0]     addr_b,
    output logic [WIDTH_OUT-1:0] dout_b
);

    // Stored as lanes so the narrow read is a plain two-level index.
    logic [RATIO-1:0][WIDTH_OUT-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr_a] <= din_a;
        end
    end

    assign dout_b = mem[addr_b[AW+LW-1:LW]][addr_b[LW-1:0]];

endmodule

// File: rtl/asymmetric_fifo.sv
// -----------------------------------------------------------------------------
// asymmetric_fifo
// Wide-in / narrow-out FIFO. Each accepted WIDTH_IN word is streamed out as
// RATIO consecutive WIDTH_OUT lanes, LSB lane first, on a valid/ready port
// with a registered output stage.
// Ports:
//   clk, rst_n          - clock, async active-low reset
//   flush               - synchronous clear of pointers, count, output stage
//   wr_en, wr_data      - write request and wide word
//   full, overflow      - no free entry / one-cycle pulse on rejected write
//   wr_count            - occupied wide entries
//   out_data, out_valid - output lane and its valid
//   out_ready           - consumer accepts out_data
// -----------------------------------------------------------------------------
module asymmetric_fifo
    import asymmetric_fifo_pkg::*;
#(
    parameter int WIDTH_IN   = 64,
    parameter int WIDTH_OUT  = 16,
    parameter int DEPTH      = 32,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  wr_en,
    input  logic [WIDTH_IN-1:0]   wr_data,
    output logic                  full,
    output logic                  overflow,
    output logic [ADDR_WIDTH:0]   wr_count,
    output logic [WIDTH_OUT-1:0]  out_data,
    output logic                  out_valid,
    input  logic                  out_ready
);

    localparam int RATIO      = calc_ratio(WIDTH_IN, WIDTH_OUT);
    localparam int LANE_WIDTH = calc_lane_width(RATIO);
    localparam int CNT_WIDTH  = calc_count_width(ADDR_WIDTH);

    logic [ADDR_WIDTH-1:0] wr_ptr_q,   wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_entry_q, rd_entry_d;
    logic [LANE_WIDTH-1:0] rd_lane_q,  rd_lane_d;
    logic [CNT_WIDTH-1:0]  cnt_q,      cnt_d;
    logic                  valid_q,    valid_d;
    logic                  ovf_q,      ovf_d;
    logic [WIDTH_OUT-1:0]  data_q,     data_d;

    logic                  full_w;
    logic                  wr_accept;
    logic                  load;
    logic                  last_lane;
    logic                  entry_free;
    logic [WIDTH_OUT-1:0]  ram_lane;

    assign full_w     = (cnt_q == CNT_WIDTH'(DEPTH));
    assign wr_accept  = wr_en && !full_w;
    assign load       = (!valid_q || out_ready) && (cnt_q != '0);
    assign last_lane  = (rd_lane_q == LANE_WIDTH'(RATIO - 1));
    // An entry stays counted until its last lane sits in the output register.
    assign entry_free = load && last_lane;

    asymmetric_distributed_ram #(
        .WIDTH_IN  (WIDTH_IN),
        .WIDTH_OUT (WIDTH_OUT),
        .DEPTH     (DEPTH)
    ) u_ram (
        .clk    (clk),
        .we     (wr_accept && !flush),
        .addr_a (wr_ptr_q),
        .din_a  (wr_data),
        .addr_b ({rd_entry_q, rd_lane_q}),
        .dout_b (ram_lane)
    );

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_entry_d = rd_entry_q;
        rd_lane_d  = rd_lane_q;
        cnt_d      = cnt_q;
        valid_d    = valid_q;
        ovf_d      = 1'b0;
        data_d     = data_q;

        if (flush) begin
            wr_ptr_d   = '0;
            rd_entry_d = '0;
            rd_lane_d  = '0;
            cnt_d      = '0;
            valid_d    = 1'b0;
            data_d     = '0;
        end else begin
            ovf_d = wr_en && full_w;

            if (wr_accept) begin
                wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
            end

            if (load) begin
                data_d  = ram_lane;
                valid_d = 1'b1;
                if (last_lane) begin
                    rd_lane_d  = '0;
                    rd_entry_d = rd_entry_q + ADDR_WIDTH'(1);
                end else begin
                    rd_lane_d  = rd_lane_q + LANE_WIDTH'(1);
                end
            end else if (valid_q && out_ready) begin
                // Consumer took the last lane and nothing is queued behind it.
                valid_d = 1'b0;
            end

            case ({wr_accept, entry_free})
                2'b10:   cnt_d = cnt_q + CNT_WIDTH'(1);
                2'b01:   cnt_d = cnt_q - CNT_WIDTH'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_entry_q <= '0;
            rd_lane_q  <= '0;
            cnt_q      <= '0;
            valid_q    <= 1'b0;
            ovf_q      <= 1'b0;
            data_q     <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_entry_q <= rd_entry_d;
            rd_lane_q  <= rd_lane_d;
            cnt_q      <= cnt_d;
            valid_q    <= valid_d;
            ovf_q      <= ovf_d;
            data_q     <= data_d;
        end
    end

    assign full      = full_w;
    assign overflow  = ovf_q;
    assign wr_count  = cnt_q;
    assign out_data  = data_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_asymmetric_fifo.sv
// -----------------------------------------------------------------------------
// tb_asymmetric_fifo
// Self-checking bench for asymmetric_fifo (64-bit in, 16-bit lanes, 32 deep).
// Expected lanes go into a scoreboard queue when a write is driven and are
// popped by a negedge monitor on every out_valid && out_ready handshake.
// -----------------------------------------------------------------------------
module tb_asymmetric_fifo;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        wr_en;
    logic [63:0] wr_data;
    logic        full;
    logic        overflow;
    logic [5:0]  wr_count;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] sb[$];

    logic        prev_hold  = 1'b0;
    logic        prev_gap   = 1'b0;
    logic [15:0] prev_data  = '0;

    typedef struct {
        logic        wr_en;
        logic [63:0] wr_data;
        logic        out_ready;
        logic        exp_valid;
        logic [15:0] exp_data;
        logic [5:0]  exp_count;
        logic        exp_full;
        logic        exp_ovf;
    } vec_t;

    vec_t tbl[6];

    asymmetric_fifo dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .full      (full),
        .overflow  (overflow),
        .wr_count  (wr_count),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_lanes(input logic [63:0] d);
        for (int l = 0; l < 4; l++) begin
            sb.push_back(d[l*16 +: 16]);
        end
    endtask

    task automatic do_write(input logic [63:0] d, input bit accept);
        wr_en   = 1'b1;
        wr_data = d;
        if (accept) push_lanes(d);
        step();
        wr_en = 1'b0;
    endtask

    task automatic apply_table();
        for (int i = 0; i < 6; i++) begin
            wr_en     = tbl[i].wr_en;
            wr_data   = tbl[i].wr_data;
            out_ready = tbl[i].out_ready;
            if (tbl[i].wr_en) push_lanes(tbl[i].wr_data);
            step();
            check($sformatf("tbl%0d_valid", i), 64'(out_valid), 64'(tbl[i].exp_valid));
            check($sformatf("tbl%0d_data", i),  64'(out_data),  64'(tbl[i].exp_data));
            check($sformatf("tbl%0d_count", i), 64'(wr_count),  64'(tbl[i].exp_count));
            check($sformatf("tbl%0d_full", i),  64'(full),      64'(tbl[i].exp_full));
            check($sformatf("tbl%0d_ovf", i),   64'(overflow),  64'(tbl[i].exp_ovf));
        end
        wr_en = 1'b0;
    endtask

    task automatic drain(input int budget);
        out_ready = 1'b1;
        for (int c = 0; c < budget; c++) begin
            if (sb.size() == 0 && !out_valid) break;
            step();
        end
        check("drain_sb_empty", 64'(sb.size()), 64'd0);
        check("drain_valid",    64'(out_valid), 64'd0);
        check("drain_count",    64'(wr_count),  64'd0);
    endtask

    function automatic logic [63:0] mk_word(input int i);
        logic [63:0] d;
        for (int l = 0; l < 4; l++) begin
            d[l*16 +: 16] = 16'h5000 | 16'(i * 4 + l);
        end
        return d;
    endfunction

    // Handshake scoreboard, hold stability and no-gap checks.
    always @(negedge clk) begin
        if (!rst_n || flush) begin
            prev_hold = 1'b0;
            prev_gap  = 1'b0;
        end else begin
            if (prev_hold) begin
                check("hold_valid", 64'(out_valid), 64'd1);
                check("hold_data",  64'(out_data),  64'(prev_data));
            end
            if (prev_gap) begin
                check("no_gap_valid", 64'(out_valid), 64'd1);
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL lane_unexpected: got %0h expected no lane at %0t", out_data, $time);
                end else begin
                    check("lane", 64'(out_data), 64'(sb.pop_front()));
                end
            end
            prev_hold = out_valid && !out_ready;
            prev_data = out_data;
            prev_gap  = (!out_valid || out_ready) && (wr_count != 6'd0);
        end
    end

    initial begin
        //            wr  data                    rdy val data      cnt full ovf
        tbl[0] = '{1'b1, 64'h4444_3333_2222_1111, 1'b1, 1'b0, 16'h0000, 6'd1, 1'b0, 1'b0};
        tbl[1] = '{1'b0, 64'h0,                   1'b1, 1'b1, 16'h1111, 6'd1, 1'b0, 1'b0};
        tbl[2] = '{1'b0, 64'h0,                   1'b1, 1'b1, 16'h2222, 6'd1, 1'b0, 1'b0};
        tbl[3] = '{1'b0, 64'h0,                   1'b1, 1'b1, 16'h3333, 6'd1, 1'b0, 1'b0};
        tbl[4] = '{1'b0, 64'h0,                   1'b1, 1'b1, 16'h4444, 6'd0, 1'b0, 1'b0};
        tbl[5] = '{1'b0, 64'h0,                   1'b1, 1'b0, 16'h4444, 6'd0, 1'b0, 1'b0};

        rst_n     = 1'b0;
        flush     = 1'b0;
        wr_en     = 1'b0;
        wr_data   = '0;
        out_ready = 1'b0;
        step();
        step();
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_count", 64'(wr_count),  64'd0);
        check("rst_full",  64'(full),      64'd0);
        check("rst_ovf",   64'(overflow),  64'd0);
        check("rst_data",  64'(out_data),  64'd0);
        rst_n = 1'b1;
        step();

        // 1: single word, lanes LSB first
        apply_table();

        // 2: fill to full with out_ready low
        out_ready = 1'b0;
        for (int i = 0; i < 32; i++) begin
            do_write(64'(i), 1'b1);
        end
        check("fill_full",  64'(full),      64'd1);
        check("fill_count", 64'(wr_count),  64'd32);
        check("fill_valid", 64'(out_valid), 64'd1);
        check("fill_data",  64'(out_data),  64'd0);
        do_write(64'd32, 1'b0);
        check("ovf_pulse", 64'(overflow), 64'd1);
        check("ovf_count", 64'(wr_count), 64'd32);
        step();
        check("ovf_clear", 64'(overflow), 64'd0);

        // 3: write on the same edge that frees entry 0 is still rejected
        out_ready = 1'b1;
        step();
        step();
        check("pre_free_count", 64'(wr_count), 64'd32);
        do_write(64'hBAD0_BAD0_BAD0_BAD0, 1'b0);
        check("free_edge_ovf",   64'(overflow), 64'd1);
        check("free_edge_count", 64'(wr_count), 64'd31);
        do_write(64'h0000_0000_0000_0064, 1'b1);
        check("refill_count", 64'(wr_count), 64'd32);
        check("refill_ovf",   64'(overflow), 64'd0);
        out_ready = 1'b0;
        step();
        drain(400);

        // 4: random backpressure over 8 entries
        begin
            int w = 0;
            for (int c = 0; c < 400; c++) begin
                if (sb.size() == 0 && w == 8 && !out_valid) break;
                wr_en = (w < 8) && ($urandom_range(0, 1) == 1);
                if (wr_en) begin
                    wr_data = mk_word(w);
                    push_lanes(wr_data);
                    w++;
                end
                out_ready = ($urandom_range(0, 2) != 0);
                step();
            end
            wr_en = 1'b0;
            check("rand_writes", 64'(w), 64'd8);
            drain(100);
        end

        // 5: flush mid-entry together with a write
        out_ready = 1'b1;
        do_write(64'h8888_7777_6666_5555, 1'b1);
        step();
        step();
        step();
        check("pre_flush_data", 64'(out_data), 64'h7777);
        out_ready = 1'b0;
        flush     = 1'b1;
        wr_en     = 1'b1;
        wr_data   = 64'h9999_9999_9999_9999;
        sb.delete();
        step();
        flush = 1'b0;
        wr_en = 1'b0;
        check("flush_valid", 64'(out_valid), 64'd0);
        check("flush_count", 64'(wr_count),  64'd0);
        check("flush_full",  64'(full),      64'd0);
        check("flush_ovf",   64'(overflow),  64'd0);
        step();
        check("flush_write_lost_count", 64'(wr_count),  64'd0);
        check("flush_write_lost_valid", 64'(out_valid), 64'd0);
        out_ready = 1'b1;
        do_write(64'hDDDD_CCCC_BBBB_AAAA, 1'b1);
        step();
        check("post_flush_valid", 64'(out_valid), 64'd1);
        check("post_flush_data",  64'(out_data),  64'hAAAA);
        drain(50);

        // 6: async reset between edges while streaming
        out_ready = 1'b1;
        do_write(64'hF4F4_F3F3_F2F2_F1F1, 1'b1);
        do_write(64'hE4E4_E3E3_E2E2_E1E1, 1'b1);
        step();
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", 64'(out_valid), 64'd0);
        check("arst_full",  64'(full),      64'd0);
        check("arst_count", 64'(wr_count),  64'd0);
        check("arst_data",  64'(out_data),  64'd0);
        sb.delete();
        step();
        rst_n = 1'b1;
        step();
        apply_table();
        check("final_sb_empty", 64'(sb.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
